// File: rtl/line_buffer_param.sv
// Parametrised single-row line buffer for the sliding-window generator.
// Stores up to LINE_MAX pixels of one line, presents a TAPS-wide horizontal
// window at the read pointer, and tracks occupancy, end-of-line and sticky
// flow-control errors. Line length W is latched from cfg_width during reset.
module line_buffer_param #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned LINE_MAX  = 512,
  parameter int unsigned TAPS      = 3,
  parameter int unsigned EDGE_MODE = 0,
  parameter int unsigned CNT_W     = $clog2(LINE_MAX + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CNT_W-1:0]       cfg_width,
  input  logic [DATA_W-1:0]      pixel_in,
  input  logic                   in_data_valid,
  output logic                   in_ready,
  input  logic                   read_data,
  output logic                   out_valid,
  output logic [TAPS*DATA_W-1:0] pixels_out,
  output logic                   line_done,
  output logic [CNT_W-1:0]       count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int unsigned AW = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;
  localparam int unsigned SW = CNT_W + 1;
  localparam logic [CNT_W-1:0] LINE_MAX_C = CNT_W'(LINE_MAX);
  localparam logic [CNT_W-1:0] TAPS_C     = CNT_W'(TAPS);
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

  logic [DATA_W-1:0] mem_q [LINE_MAX];

  logic [CNT_W-1:0] w_q, w_cfg;
  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             line_done_q, line_done_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic [CNT_W-1:0] last_col;
  logic [CNT_W-1:0] span;
  logic [CNT_W-1:0] need;
  logic             wr_acc;
  logic             rd_acc;

  // Effective line length from cfg_width: 0 or oversize means full depth.
  always_comb begin
    w_cfg = cfg_width;
    if (cfg_width == '0 || cfg_width > LINE_MAX_C) begin
      w_cfg = LINE_MAX_C;
    end else if (cfg_width < TAPS_C) begin
      w_cfg = TAPS_C;
    end
  end

  // Flow control; replicate mode only needs the pixels up to end of line.
  always_comb begin
    last_col = w_q - ONE_C;
    span     = w_q - rd_ptr_q;
    need     = TAPS_C;
    if (EDGE_MODE != 0 && span < TAPS_C) begin
      need = span;
    end
    in_ready  = (count_q < w_q);
    out_valid = (count_q >= need);
    wr_acc    = in_data_valid && in_ready;
    rd_acc    = read_data && out_valid;
  end

  // Asynchronous window read; tap 0 (oldest) lands in the MSBs.
  always_comb begin
    logic [SW-1:0] col;
    col        = '0;
    pixels_out = '0;
    for (int i = 0; i < TAPS; i++) begin
      col = {1'b0, rd_ptr_q} + SW'(i);
      if (col > {1'b0, last_col}) begin
        if (EDGE_MODE == 0) begin
          col = col - {1'b0, w_q};
        end else begin
          col = {1'b0, last_col};
        end
      end
      pixels_out[(TAPS-1-i)*DATA_W +: DATA_W] = mem_q[AW'(col)];
    end
  end

  // Next-state: pointer wrap at W, occupancy, end-of-line and sticky flags.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    line_done_d = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_acc) begin
      wr_ptr_d = (wr_ptr_q == last_col) ? '0 : wr_ptr_q + ONE_C;
    end
    if (rd_acc) begin
      rd_ptr_d    = (rd_ptr_q == last_col) ? '0 : rd_ptr_q + ONE_C;
      line_done_d = (rd_ptr_q == last_col);
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
    if (in_data_valid && !in_ready) begin
      overflow_d = 1'b1;
    end
    if (read_data && !out_valid) begin
      underflow_d = 1'b1;
    end
  end

  // State registers with synchronous reset; W is only captured in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_q         <= w_cfg;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      line_done_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      line_done_q <= line_done_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Pixel storage; never cleared, writes suppressed during reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem_q[AW'(wr_ptr_q)] <= pixel_in;
    end
  end

  assign line_done = line_done_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_line_buffer_param.sv
// Bench for line_buffer_param: a wrap-mode and a replicate-mode instance
// share one stimulus stream and are checked against a stream-level model.
module tb_line_buffer_param;

  localparam int unsigned DW = 8;
  localparam int unsigned LM = 512;
  localparam int unsigned TP = 3;
  localparam int unsigned CW = $clog2(LM + 1);
  localparam int unsigned HN = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [CW-1:0] cfg_width;
  logic [DW-1:0] pixel_in;
  logic          in_data_valid;
  logic          read_data;

  logic [1:0]       in_ready, out_valid, line_done, overflow, underflow;
  logic [TP*DW-1:0] pix_out [2];
  logic [CW-1:0]    count [2];

  line_buffer_param #(.DATA_W(DW), .LINE_MAX(LM), .TAPS(TP), .EDGE_MODE(0)) u_wrap (
    .clk(clk), .rst(rst), .cfg_width(cfg_width), .pixel_in(pixel_in),
    .in_data_valid(in_data_valid), .in_ready(in_ready[0]), .read_data(read_data),
    .out_valid(out_valid[0]), .pixels_out(pix_out[0]), .line_done(line_done[0]),
    .count(count[0]), .overflow(overflow[0]), .underflow(underflow[0]));

  line_buffer_param #(.DATA_W(DW), .LINE_MAX(LM), .TAPS(TP), .EDGE_MODE(1)) u_repl (
    .clk(clk), .rst(rst), .cfg_width(cfg_width), .pixel_in(pixel_in),
    .in_data_valid(in_data_valid), .in_ready(in_ready[1]), .read_data(read_data),
    .out_valid(out_valid[1]), .pixels_out(pix_out[1]), .line_done(line_done[1]),
    .count(count[1]), .overflow(overflow[1]), .underflow(underflow[1]));

  // Model: every pixel ever written since reset, plus totals written/read.
  logic [DW-1:0] hist [2][HN];
  int            wr_tot [2];
  int            rd_tot [2];
  bit            m_ld [2];
  bit            m_ovf [2];
  bit            m_unf [2];
  int            w;
  bit            model_ok;

  int n_cmp;
  int n_bad;

  task automatic chk(input string tag, input int m, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s inst%0d observed=%0h expected=%0h", tag, m, obs, exp);
    end
  endtask

  function automatic int m_cnt(input int m);
    return wr_tot[m] - rd_tot[m];
  endfunction

  function automatic bit m_valid(input int m);
    int rc, need;
    rc   = rd_tot[m] % w;
    need = TP;
    if (m == 1 && (w - rc) < need) need = w - rc;
    return m_cnt(m) >= need;
  endfunction

  function automatic logic [TP*DW-1:0] m_win(input int m);
    logic [TP*DW-1:0] r;
    int rc, k;
    r  = '0;
    rc = rd_tot[m] % w;
    for (int i = 0; i < TP; i++) begin
      k = i;
      if (m == 1 && k > w - 1 - rc) k = w - 1 - rc;
      r[(TP-1-i)*DW +: DW] = hist[m][(rd_tot[m] + k) % HN];
    end
    return r;
  endfunction

  function automatic int clamp_w(input int c);
    if (c == 0 || c > int'(LM)) return LM;
    if (c < int'(TP)) return TP;
    return c;
  endfunction

  // One clock: drive, check all outputs mid-cycle, advance the model.
  task automatic step(input bit r, input int cfg, input bit wv, input logic [DW-1:0] p, input bit rv);
    bit ir, ov;
    rst = r; cfg_width = CW'(cfg); in_data_valid = wv; pixel_in = p; read_data = rv;
    @(negedge clk);
    if (model_ok) begin
      for (int m = 0; m < 2; m++) begin
        chk("count", m, 32'(count[m]), 32'(m_cnt(m)));
        chk("in_ready", m, 32'(in_ready[m]), 32'(m_cnt(m) < w));
        chk("out_valid", m, 32'(out_valid[m]), 32'(m_valid(m)));
        chk("line_done", m, 32'(line_done[m]), 32'(m_ld[m]));
        chk("overflow", m, 32'(overflow[m]), 32'(m_ovf[m]));
        chk("underflow", m, 32'(underflow[m]), 32'(m_unf[m]));
        if (m_valid(m)) chk("window", m, 32'(pix_out[m]), 32'(m_win(m)));
      end
    end
    for (int m = 0; m < 2; m++) begin
      if (r) begin
        wr_tot[m] = 0; rd_tot[m] = 0; m_ld[m] = 0; m_ovf[m] = 0; m_unf[m] = 0;
      end else begin
        ir = m_cnt(m) < w;
        ov = m_valid(m);
        m_ld[m] = rv && ov && (rd_tot[m] % w == w - 1);
        if (wv && !ir) m_ovf[m] = 1;
        if (rv && !ov) m_unf[m] = 1;
        if (rv && ov) rd_tot[m]++;
        if (wv && ir) begin
          hist[m][wr_tot[m] % HN] = p;
          wr_tot[m]++;
        end
      end
    end
    if (r) begin
      w = clamp_w(cfg);
      model_ok = 1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cfg;
    bit r;
    n_cmp = 0; n_bad = 0; model_ok = 0; w = LM;
    for (int m = 0; m < 2; m++) begin
      wr_tot[m] = 0; rd_tot[m] = 0; m_ld[m] = 0; m_ovf[m] = 0; m_unf[m] = 0;
    end

    // Line of 8: load, window, wrap across the line, line_done timing.
    step(1, 8, 0, 0, 0);
    chk("rst_count", 0, 32'(count[0]), 0);
    chk("rst_flags", 0, {30'd0, overflow[0], underflow[0]}, 0);
    for (int i = 0; i < 8; i++) step(0, 8, 1, DW'(10 + i), 0);
    chk("A_full_count", 0, 32'(count[0]), 8);
    chk("A_full_ready", 0, 32'(in_ready[0]), 0);
    chk("A_win0", 0, 32'(pix_out[0]), 32'h0a0b0c);
    repeat (6) step(0, 8, 0, 0, 1);
    chk("A_ld_rd5", 0, 32'(line_done[0]), 0);
    chk("A_repl_rd6", 1, 32'(pix_out[1]), 32'h101111);
    step(0, 8, 1, 8'd18, 0);
    step(0, 8, 1, 8'd19, 0);
    chk("A_wrap_rd6", 0, 32'(pix_out[0]), 32'h101112);
    step(0, 8, 0, 0, 1);
    chk("A_wrap_rd7", 0, 32'(pix_out[0]), 32'h111213);
    chk("A_repl_rd7", 1, 32'(pix_out[1]), 32'h111111);
    step(0, 8, 0, 0, 1);
    chk("A_ld_pulse", 0, 32'(line_done[0]), 1);
    chk("A_ld_pulse", 1, 32'(line_done[1]), 1);
    step(0, 8, 0, 0, 0);
    chk("A_ld_one_cycle", 0, 32'(line_done[0]), 0);
    step(0, 8, 0, 0, 1);
    chk("A_underflow", 0, 32'(underflow[0]), 1);
    chk("A_uf_count", 1, 32'(count[1]), 2);

    // Full buffer: write+read together while full, then while not full.
    step(1, 8, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 8, 1, DW'(20 + i), 0);
    step(0, 8, 1, 8'd99, 1);
    chk("B_overflow", 0, 32'(overflow[0]), 1);
    chk("B_count7", 0, 32'(count[0]), 7);
    step(0, 8, 1, 8'd28, 1);
    chk("B_count_hold", 1, 32'(count[1]), 7);
    chk("B_ovf_sticky", 1, 32'(overflow[1]), 1);

    // Empty buffer: read ignored, window valid only from the third pixel.
    step(1, 8, 0, 0, 0);
    step(0, 8, 0, 0, 1);
    chk("C_underflow", 0, 32'(underflow[0]), 1);
    chk("C_count0", 0, 32'(count[0]), 0);
    step(0, 8, 1, 8'h51, 0);
    step(0, 8, 1, 8'h52, 0);
    chk("C_two_invalid", 0, 32'(out_valid[0]), 0);
    step(0, 8, 1, 8'h53, 0);
    chk("C_three_valid", 0, 32'(out_valid[0]), 1);

    // cfg_width=0 selects full depth; pointers wrap after 512.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 512; i++) step(0, 5, 1, DW'(i), 0);
    chk("D_512_count", 0, 32'(count[0]), 512);
    chk("D_512_ready", 0, 32'(in_ready[0]), 0);
    step(0, 5, 0, 0, 1);
    step(0, 5, 1, 8'haa, 0);
    repeat (509) step(0, 5, 0, 0, 1);
    chk("D_wrap512", 0, 32'(pix_out[0]), 32'hfeffaa);
    chk("D_repl512", 1, 32'(pix_out[1]), 32'hfeffff);

    // cfg_width below TAPS clamps to TAPS; later cfg changes are ignored.
    step(1, 2, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 8, 1, DW'(8'h31 + i), 0);
    step(0, 8, 0, 0, 0);
    chk("D_w3_ready", 0, 32'(in_ready[0]), 0);
    chk("D_w3_count", 0, 32'(count[0]), 3);
    step(0, 8, 0, 0, 1);
    step(0, 8, 1, 8'h34, 0);
    chk("D_w3_wrap", 0, 32'(pix_out[0]), 32'h323334);
    chk("D_w3_repl", 1, 32'(pix_out[1]), 32'h323333);

    // Reset mid-line discards data, clears flags, restarts at address 0.
    step(1, 8, 0, 0, 0);
    step(0, 8, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 8, 1, DW'(1 + i), 0);
    step(0, 8, 0, 0, 1);
    step(0, 8, 0, 0, 1);
    step(1, 8, 0, 0, 0);
    chk("E_count0", 0, 32'(count[0]), 0);
    chk("E_invalid", 0, 32'(out_valid[0]), 0);
    chk("E_flags", 0, 32'(underflow[0]), 0);
    chk("E_no_ld", 0, 32'(line_done[0]), 0);
    for (int i = 0; i < 3; i++) step(0, 8, 1, DW'(42 + i), 0);
    chk("E_addr0", 0, 32'(pix_out[0]), 32'h2a2b2c);

    // Randomised traffic with occasional resets and assorted widths.
    for (int c = 0; c < 2000; c++) begin
      r = (c % 400 == 0) || ($urandom_range(0, 199) == 0);
      case ($urandom_range(0, 5))
        0:       cfg = 0;
        1:       cfg = $urandom_range(1, 3);
        2:       cfg = $urandom_range(4, 12);
        3:       cfg = 512;
        4:       cfg = $urandom_range(513, 1023);
        default: cfg = $urandom_range(13, 100);
      endcase
      step(r, cfg, $urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 2) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/line_buffer_param.md
Name: line_buffer_param

Overview:
- Parametrised successor to the single-line 8-bit/256-pixel/3-tap line buffer used ahead of the Canny convolution stages.
- Generalised in pixel width, maximum line length, window tap count and runtime line length.
- Adds occupancy tracking, in/out flow control, end-of-line marking, border replication and sticky error flags.
- One instance feeds one row of the sliding-window generator; several are chained to build a K×K window.

Parameters:
- DATA_W, 8, bits per pixel.
- LINE_MAX, 512, storage depth in pixels; maximum line length.
- TAPS, 3, horizontal window width; range 1..8, must be ≤ LINE_MAX.
- EDGE_MODE, 0, border handling. 0 = wrap (modulo line length). 1 = replicate last pixel of line.
- CNT_W, $clog2(LINE_MAX+1), width of the occupancy count.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_width  in  CNT_W  active line length; sampled only in a reset cycle.
- pixel_in  in  DATA_W  write pixel.
- in_data_valid  in  1  write request.
- in_ready  out  1  buffer can accept a write this cycle.
- read_data  in  1  consume one pixel / advance window by one.
- out_valid  out  1  pixels_out holds a complete window.
- pixels_out  out  TAPS*DATA_W  window; tap 0 (oldest, at read pointer) in MSBs.
- line_done  out  1  one-cycle pulse after the last pixel of a line is consumed.
- count  out  CNT_W  pixels written but not yet consumed.
- overflow  out  1  sticky: write attempted while !in_ready.
- underflow  out  1  sticky: read attempted while !out_valid.

Behaviour:
- Reset (rst=1 at a clock edge):
  - wr_ptr, rd_ptr, count, line_done, overflow and underflow all go to 0.
  - Storage contents are not cleared.
  - Effective width W latched: W = cfg_width, clamped to LINE_MAX when cfg_width is 0 or > LINE_MAX, and to TAPS when cfg_width < TAPS.
  - W holds until the next reset. cfg_width is ignored outside reset.
- Addressing:
  - Pointers run 0..W-1 and wrap to 0 after W-1, not at a power of two.
  - Tap i address = (rd_ptr+i) mod W.
- Write:
  - Accepted when in_data_valid && in_ready; stores at wr_ptr, then wr_ptr advances.
  - in_ready = (count < W), combinational from registered state.
  - Write while !in_ready: dropped, no pointer or count change, overflow set.
- Read:
  - Accepted when read_data && out_valid; rd_ptr advances by 1 (consumes one pixel, not TAPS).
  - Read while !out_valid: ignored, underflow set.
- count update:
  - +1 on write only, -1 on read only.
  - Unchanged on simultaneous accepted write and read, including at count = W (a read frees the slot in the same cycle only for the next cycle's in_ready; in_ready is not combinationally dependent on read_data).
- out_valid:
  - EDGE_MODE 0: count ≥ TAPS.
  - EDGE_MODE 1: count ≥ min(TAPS, W - rd_ptr).
  - In EDGE_MODE 1, any tap whose column rd_ptr+i > W-1 outputs pixel at column W-1.
- pixels_out:
  - Combinational (asynchronous) read; zero latency from pointer state.
  - Value is don't-care when !out_valid.
- line_done:
  - Registered; high for exactly one cycle, the cycle after an accepted read with rd_ptr = W-1.
- Latency: write at cycle N is visible in pixels_out/count at cycle N+1.
- Reset mid-line: all pending data discarded (count = 0); no line_done pulse is generated for the aborted line.
- Flags clear only on rst.

Test Plan:
- Reset with cfg_width=8, TAPS=3, EDGE_MODE=0; write 10,11,...,17 -> count=8, in_ready=0. Window check: out_valid=1 and pixels_out={10,11,12}.
  - Read 6 times -> pixels_out={16,17,10} (wrap across line).
  - The 6th read at rd_ptr=5 does not pulse line_done; the 8th read (rd_ptr=7) pulses line_done the next cycle.
- Full buffer (count=8): assert write+read same cycle -> write dropped, overflow=1 (in_ready was 0), read accepted, count=7.
  - Then simultaneous write+read -> count stays 7, overflow stays 1.
- EDGE_MODE=1, W=8, pixels 10..17 loaded, read to rd_ptr=6 -> out_valid=1, pixels_out={16,17,17}.
  - At rd_ptr=7 -> {17,17,17}.
  - Next read -> line_done pulse, rd_ptr=0.
- Empty buffer: read_data=1 -> underflow=1, rd_ptr and count unchanged.
  - Write 2 pixels -> out_valid=0 (EDGE_MODE 0).
  - 3rd write -> out_valid=1 next cycle.
- Reset with cfg_width=0, then cfg_width=2 (TAPS=3) -> W=LINE_MAX (512), then W=3.
  - Confirm wrap after 512 and after 3 writes respectively.
  - Change cfg_width outside reset -> no effect.
- Mid-line reset after 5 writes and 2 reads -> count=0, out_valid=0, flags cleared, no line_done.
  - First post-reset write lands at address 0.
